// File: rtl/button_event_capture.sv
// -----------------------------------------------------------------------------
// button_event_capture
//
// Captures pushbutton activity for a processor that polls over gpio. Each
// button is synchronized, debounced, and turned into one-cycle events by a
// small per-button FSM. Events set a sticky pending flag. An event that
// arrives while pending is still set also sets a sticky overflow flag.
//
// Build option:
//   BTN_AUTOREPEAT_EN - when defined, a button held past REPEAT_DELAY_CYCLES
//                       produces further events every REPEAT_RATE_CYCLES.
//                       When undefined, each press produces exactly one
//                       event, and the REPEAT_* parameters have no effect.
//
// Ports:
//   FPGA_CLK1_50       in   system clock (50 MHz)
//   reset              in   asynchronous active-high reset
//   btn_n[NBTN-1:0]    in   raw asynchronous pushbuttons, active-low
//   clr[NBTN-1:0]      in   per-button clear of pending/overflow (level)
//   btn_level          out  debounced level, 1 = pressed
//   event_pulse        out  one-cycle strobe per press / repeat event
//   pending            out  sticky event flag
//   overflow           out  sticky flag: event seen while pending was set
//
// Press latency: btn_n stable low -> event_pulse high after exactly
// DEBOUNCE_CYCLES+3 clock edges (2 synchronizer edges, DEBOUNCE_CYCLES
// counting edges, 1 FSM edge). btn_level is a registered copy of the internal
// debounced level. It therefore moves on the same edge as the press event.
// -----------------------------------------------------------------------------
module button_event_capture #(
    parameter int NBTN                = 2,
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter int REPEAT_DELAY_CYCLES = 20000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic            FPGA_CLK1_50,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_n,
    input  logic [NBTN-1:0] clr,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] event_pulse,
    output logic [NBTN-1:0] pending,
    output logic [NBTN-1:0] overflow
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);

`ifdef BTN_AUTOREPEAT_EN
    localparam int TM_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int              TM_W       = $clog2(TM_MAX + 1);
    localparam logic [TM_W-1:0] TM_ZERO    = TM_W'(0);
    localparam logic [TM_W-1:0] TM_ONE     = TM_W'(1);
    localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TM_W-1:0] RATE_LAST  = TM_W'(REPEAT_RATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_HOLD_DELAY = 2'd1,
        ST_REPEAT     = 2'd2
    } btn_state_t;
`else
    typedef enum logic [0:0] {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } btn_state_t;
`endif

    // Synchronizer stages hold the raw (active-low) value; 1 means released.
    logic [NBTN-1:0] sync1_r;
    logic [NBTN-1:0] sync2_r;
    logic [NBTN-1:0] pressed_s;

    assign pressed_s = ~sync2_r;

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
        if (reset) begin
            sync1_r <= {NBTN{1'b1}};
            sync2_r <= {NBTN{1'b1}};
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        logic [DB_W-1:0] db_cnt_r;
        logic            level_r;      // internal debounced level
        logic            level_d_r;    // previous level, for rise detection
        logic            btn_level_r;
        logic            event_r;
        logic            pending_r;
        logic            overflow_r;
        btn_state_t      state_r;

        // Debouncer: the count advances only while the synchronized value
        // disagrees with the level, and any agreeing cycle restarts it.
        // The level flips on the edge that completes DEBOUNCE_CYCLES
        // disagreeing cycles.
        always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
            if (reset) begin
                db_cnt_r <= DB_ZERO;
                level_r  <= 1'b0;
            end else if (pressed_s[i] == level_r) begin
                db_cnt_r <= DB_ZERO;
                level_r  <= level_r;
            end else if (db_cnt_r == DB_LAST) begin
                db_cnt_r <= DB_ZERO;
                level_r  <= pressed_s[i];
            end else if (db_cnt_r != DB_MAX) begin
                db_cnt_r <= db_cnt_r + DB_ONE;
                level_r  <= level_r;
            end else begin
                db_cnt_r <= db_cnt_r;
                level_r  <= level_r;
            end
        end

        // Registered copy of the debounced level for the output port.
        always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
            if (reset) begin
                btn_level_r <= 1'b0;
                level_d_r   <= 1'b0;
            end else begin
                btn_level_r <= level_r;
                level_d_r   <= level_r;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [TM_W-1:0] timer_r;

        // Press / hold / repeat FSM. The event strobe is registered.
        // A release never produces an event.
        always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
            if (reset) begin
                state_r <= ST_RELEASED;
                timer_r <= TM_ZERO;
                event_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_RELEASED: begin
                        timer_r <= TM_ZERO;
                        if (level_r && !level_d_r) begin
                            event_r <= 1'b1;
                            state_r <= ST_HOLD_DELAY;
                        end else begin
                            event_r <= 1'b0;
                            state_r <= ST_RELEASED;
                        end
                    end
                    ST_HOLD_DELAY: begin
                        if (!level_r) begin
                            event_r <= 1'b0;
                            timer_r <= TM_ZERO;
                            state_r <= ST_RELEASED;
                        end else if (timer_r == DELAY_LAST) begin
                            event_r <= 1'b1;
                            timer_r <= TM_ZERO;
                            state_r <= ST_REPEAT;
                        end else begin
                            event_r <= 1'b0;
                            timer_r <= timer_r + TM_ONE;
                            state_r <= ST_HOLD_DELAY;
                        end
                    end
                    ST_REPEAT: begin
                        if (!level_r) begin
                            event_r <= 1'b0;
                            timer_r <= TM_ZERO;
                            state_r <= ST_RELEASED;
                        end else if (timer_r == RATE_LAST) begin
                            event_r <= 1'b1;
                            timer_r <= TM_ZERO;
                            state_r <= ST_REPEAT;
                        end else begin
                            event_r <= 1'b0;
                            timer_r <= timer_r + TM_ONE;
                            state_r <= ST_REPEAT;
                        end
                    end
                    default: begin
                        event_r <= 1'b0;
                        timer_r <= TM_ZERO;
                        state_r <= ST_RELEASED;
                    end
                endcase
            end
        end
`else
        // Press FSM without auto-repeat: exactly one event per press.
        always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
            if (reset) begin
                state_r <= ST_RELEASED;
                event_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_RELEASED: begin
                        if (level_r && !level_d_r) begin
                            event_r <= 1'b1;
                            state_r <= ST_PRESSED;
                        end else begin
                            event_r <= 1'b0;
                            state_r <= ST_RELEASED;
                        end
                    end
                    ST_PRESSED: begin
                        event_r <= 1'b0;
                        if (!level_r) begin
                            state_r <= ST_RELEASED;
                        end else begin
                            state_r <= ST_PRESSED;
                        end
                    end
                    default: begin
                        event_r <= 1'b0;
                        state_r <= ST_RELEASED;
                    end
                endcase
            end
        end
`endif

        // Sticky flags. A clear in the same cycle as an event keeps the event:
        // pending ends set and overflow ends cleared.
        always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
            if (reset) begin
                pending_r  <= 1'b0;
                overflow_r <= 1'b0;
            end else if (clr[i]) begin
                pending_r  <= event_r;
                overflow_r <= 1'b0;
            end else if (event_r) begin
                pending_r  <= 1'b1;
                overflow_r <= overflow_r | pending_r;
            end else begin
                pending_r  <= pending_r;
                overflow_r <= overflow_r;
            end
        end

        assign btn_level[i]   = btn_level_r;
        assign event_pulse[i] = event_r;
        assign pending[i]     = pending_r;
        assign overflow[i]    = overflow_r;
    end

endmodule

// File: tb/tb_button_event_capture.sv
// -----------------------------------------------------------------------------
// tb_button_event_capture
//
// Directed bench for button_event_capture. The bench uses small timing
// parameters: DEBOUNCE=4, DELAY=20, RATE=8.
//
// A reference model runs alongside the directed stimulus. It states the
// behaviour in terms of press age:
//   - the level changes after DEBOUNCE disagreeing synchronized samples;
//   - events occur 1 edge after the level rises;
//   - with auto-repeat, further events occur at age DELAY+1+n*RATE while held;
//   - the sticky flags follow the set/clear rules.
// The model is compared against every output on every cycle.
//
// The directed scenarios also check hand-computed times. These are relative to
// the edge at which the stimulus changed, where t=0 means "driven just after
// edge 0".
// -----------------------------------------------------------------------------
module tb_button_event_capture;

    localparam int NBTN = 2;
    localparam int DEB  = 4;
    localparam int DLY  = 20;
    localparam int RATE = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NBTN-1:0] btn_n;
    logic [NBTN-1:0] clr;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] event_pulse;
    logic [NBTN-1:0] pending;
    logic [NBTN-1:0] overflow;

    int checks = 0;
    int errors = 0;

    button_event_capture #(
        .NBTN                (NBTN),
        .DEBOUNCE_CYCLES     (DEB),
        .REPEAT_DELAY_CYCLES (DLY),
        .REPEAT_RATE_CYCLES  (RATE)
    ) dut (
        .FPGA_CLK1_50 (clk),
        .reset        (reset),
        .btn_n        (btn_n),
        .clr          (clr),
        .btn_level    (btn_level),
        .event_pulse  (event_pulse),
        .pending      (pending),
        .overflow     (overflow)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NBTN-1:0] m_d1, m_d2;     // raw samples from 1 and 2 edges ago
    logic [NBTN-1:0] m_lvl;          // internal debounced level
    logic [NBTN-1:0] m_lvl_out;      // level as seen on the port
    logic [NBTN-1:0] m_ev, m_pend, m_ovf;
    int              m_run [NBTN];   // consecutive disagreeing samples
    int              m_age [NBTN];   // edges since the level rose

    task automatic model_reset();
        m_d1 = {NBTN{1'b1}};
        m_d2 = {NBTN{1'b1}};
        m_lvl = '0; m_lvl_out = '0; m_ev = '0; m_pend = '0; m_ovf = '0;
        for (int i = 0; i < NBTN; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
    endtask

    initial begin : model_cmp
        logic [NBTN-1:0] ev_n;
        model_reset();
        forever begin
            @(posedge clk);
            if (reset) begin
                model_reset();
            end else begin
                for (int i = 0; i < NBTN; i++) begin
                    ev_n[i] = 1'b0;
                    if (m_lvl[i]) begin
                        m_age[i]++;
                        if (m_age[i] == 1) ev_n[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        else if (m_age[i] >= DLY + 1 && ((m_age[i] - DLY - 1) % RATE) == 0)
                            ev_n[i] = 1'b1;
`endif
                    end
                    if (clr[i]) begin
                        m_pend[i] = m_ev[i];
                        m_ovf[i]  = 1'b0;
                    end else if (m_ev[i]) begin
                        if (m_pend[i]) m_ovf[i] = 1'b1;
                        m_pend[i] = 1'b1;
                    end
                    m_lvl_out[i] = m_lvl[i];
                    if ((!m_d2[i]) != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            m_lvl[i] = !m_lvl[i];
                            m_run[i] = 0;
                            m_age[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    m_d2[i] = m_d1[i];
                    m_d1[i] = btn_n[i];
                end
                m_ev = ev_n;
            end
            @(negedge clk);
            if (reset) model_reset();
            chk("model_btn_level", btn_level, m_lvl_out);
            chk("model_event", event_pulse, m_ev);
            chk("model_pending", pending, m_pend);
            chk("model_overflow", overflow, m_ovf);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        logic ar;
        logic exp_ev;
`ifdef BTN_AUTOREPEAT_EN
        ar = 1'b1;
`else
        ar = 1'b0;
`endif
        reset = 1'b1;
        btn_n = 2'b11;
        clr   = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_level", btn_level, 32'd0);
        chk("reset_event", event_pulse, 32'd0);
        chk("reset_pending", pending, 32'd0);
        chk("reset_overflow", overflow, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Clean press on button 0: held 10 cycles.
        btn_n[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 10) btn_n[0] = 1'b1;
            @(negedge clk);
            chk("s1_event", event_pulse[0], (k == 7));
            chk("s1_level", btn_level[0], (k >= 7 && k < 17));
            chk("s1_pending", pending[0], (k >= 8));
        end
        @(posedge clk); #1; clr = 2'b11;
        @(posedge clk); #1; clr = 2'b00;
        @(negedge clk);
        chk("s1_cleared", pending, 32'd0);

        // Bouncing button 1: toggles every 2 cycles, never debounces.
        @(posedge clk); #1;
        btn_n[1] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            btn_n[1] = (k < 20) ? (((k / 2) % 2) == 1) : 1'b1;
            @(negedge clk);
            chk("s2_level", btn_level[1], 32'd0);
            chk("s2_event", event_pulse[1], 32'd0);
            chk("s2_pending", pending[1], 32'd0);
        end

        // Long hold on button 0: 60 cycles.
        @(posedge clk); #1;
        btn_n[0] = 1'b0;
        for (int k = 1; k <= 75; k++) begin
            @(posedge clk); #1;
            if (k == 60) btn_n[0] = 1'b1;
            @(negedge clk);
            exp_ev = ar ? (k == 7 || k == 27 || k == 35 || k == 43 || k == 51 || k == 59)
                        : (k == 7);
            chk("s3_event", event_pulse[0], exp_ev);
            chk("s3_overflow", overflow[0], ar && (k >= 28));
        end

        // Both buttons pressed together; clr[0] collides with the event.
        // pending[0] is still set from the hold above.
        @(posedge clk); #1;
        btn_n = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 7)  clr[0] = 1'b1;
            if (k == 8)  clr[0] = 1'b0;
            if (k == 10) btn_n = 2'b11;
            @(negedge clk);
            chk("s4_event", event_pulse, (k == 7) ? 32'd3 : 32'd0);
            if (k == 8) begin
                chk("s4_pending0", pending[0], 32'd1);
                chk("s4_overflow0", overflow[0], 32'd0);
                chk("s4_pending1", pending[1], 32'd1);
            end
        end
        @(posedge clk); #1; clr = 2'b11;
        @(posedge clk); #1; clr = 2'b00;

        // Reset asserted mid-hold: asserted at t=15, released at t=18.
        @(posedge clk); #1;
        btn_n[0] = 1'b0;
        for (int k = 1; k <= 75; k++) begin
            @(posedge clk); #1;
            if (k == 15) reset = 1'b1;
            if (k == 18) reset = 1'b0;
            if (k == 60) btn_n[0] = 1'b1;
            @(negedge clk);
            if (k == 15) begin
                chk("s5_rst_level", btn_level, 32'd0);
                chk("s5_rst_event", event_pulse, 32'd0);
                chk("s5_rst_pending", pending, 32'd0);
                chk("s5_rst_overflow", overflow, 32'd0);
            end
            exp_ev = ar ? (k == 7 || k == 25 || k == 45 || k == 53 || k == 61)
                        : (k == 7 || k == 25);
            chk("s5_event", event_pulse[0], exp_ev);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
